// File: rtl/u765_sd_pkg.sv
// u765_sd_pkg: types shared by the sector scheduler and the FDC wrapper top level.
package u765_sd_pkg;
    typedef enum logic [2:0] {IDLE, CMD, RD_XFER, WR_FETCH, WR_XFER, DONE_WAIT, REL} sched_state_t;
    localparam int DEF_SECTOR_BYTES = 512;
    typedef logic [8:0] cnt_t;
endpackage

// File: rtl/u765_rr_arb2.sv
// u765_rr_arb2: two-way round-robin picker; prio names the drive that wins a tie.
module u765_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);
    assign gnt_o = prio_i ? (req_i[1] ? 2'b10 : {1'b0, req_i[0]})
                          : (req_i[0] ? 2'b01 : {req_i[1], 1'b0});
endmodule

// File: rtl/u765_sd_sched.sv
// u765_sd_sched: moves one sector per drive request between the FDC image buffer
// and the block-storage backend, arbitrating the two drives round-robin.
module u765_sd_sched
    import u765_sd_pkg::*;
#(
    parameter int          SECTOR_BYTES   = DEF_SECTOR_BYTES,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] sd_lba,
    input  logic [1:0]  sd_rd,
    input  logic [1:0]  sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [7:0]  sd_buff_din,
    output logic        blk_req,
    input  logic        blk_gnt,
    output logic        blk_we,
    output logic        blk_drive,
    output logic [31:0] blk_lba,
    input  logic [7:0]  blk_rd_data,
    input  logic        blk_rd_valid,
    output logic        blk_rd_ready,
    output logic [7:0]  blk_wr_data,
    output logic        blk_wr_valid,
    input  logic        blk_wr_ready,
    input  logic        blk_done,
    input  logic        blk_err,
    output logic        busy,
    output logic        err
);
    localparam cnt_t LAST = cnt_t'(SECTOR_BYTES - 1);

    sched_state_t state_q, state_d;
    cnt_t         cnt_q, cnt_d, addr_q;
    logic [23:0]  tmr_q, tmr_d;
    logic [31:0]  lba_q;
    logic [7:0]   dout_q, wdat_q;
    logic         prio_q, drv_q, we_q, fst_q, err_q, wr_q;
    logic [1:0]   gnt;
    logic         beat, abort, pend;

    u765_rr_arb2 u_arb (.req_i(sd_rd | sd_wr), .prio_i(prio_q), .gnt_o(gnt));

    always_comb begin
        beat    = (state_q == RD_XFER && blk_rd_valid) || (state_q == WR_XFER && blk_wr_ready);
        // an early blk_done is as fatal as blk_err; the error wins over a good done
        abort   = state_q != IDLE && state_q != REL &&
                  (blk_err || (blk_done && state_q != DONE_WAIT) || tmr_q == TIMEOUT_CYCLES);
        pend    = we_q ? sd_wr[drv_q] : sd_rd[drv_q];
        cnt_d   = state_q == IDLE ? '0 : beat ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        state_d = state_q;
        if (abort) state_d = REL;
        else case (state_q)
            IDLE:      state_d = |gnt ? CMD : IDLE;
            CMD:       state_d = blk_gnt ? (we_q ? WR_FETCH : RD_XFER) : CMD;
            RD_XFER:   state_d = beat && cnt_q == LAST ? DONE_WAIT : RD_XFER;
            WR_FETCH:  state_d = WR_XFER;
            WR_XFER:   state_d = beat ? (cnt_q == LAST ? DONE_WAIT : WR_FETCH) : WR_XFER;
            DONE_WAIT: state_d = blk_done ? REL : DONE_WAIT;
            REL:       state_d = pend ? REL : IDLE;
            default:   state_d = IDLE;
        endcase
        tmr_d   = (state_d != state_q || beat || state_q == IDLE || state_q == REL)
                  ? '0 : tmr_q + 24'(tmr_q != '1);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            tmr_q   <= '0;
            lba_q   <= '0;
            dout_q  <= '0;
            wdat_q  <= '0;
            prio_q  <= 1'b0;
            drv_q   <= 1'b0;
            we_q    <= 1'b0;
            fst_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            err_q   <= abort;
            wr_q    <= beat && state_q == RD_XFER;
            fst_q   <= state_d == WR_XFER && state_q != WR_XFER;
            if (beat && state_q == RD_XFER) begin
                dout_q <= blk_rd_data;
                addr_q <= cnt_q;
            end
            if (fst_q) wdat_q <= sd_buff_din;
            if (state_q == IDLE && |gnt) begin
                drv_q  <= gnt[1];
                we_q   <= ~sd_rd[gnt[1]];
                lba_q  <= sd_lba;
                prio_q <= ~gnt[1];
            end
        end
    end

    // buffer data arrives one cycle after the fetch address, so it is forwarded
    // straight through on the first WR_XFER cycle and held from then on
    assign blk_wr_data  = fst_q ? sd_buff_din : wdat_q;
    assign sd_buff_addr = (state_q == WR_FETCH || state_q == WR_XFER) ? cnt_q : addr_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = wr_q;
    assign busy         = state_q != IDLE;
    assign sd_ack       = busy && state_q != REL;
    assign blk_req      = state_q == CMD;
    assign blk_rd_ready = state_q == RD_XFER;
    assign blk_wr_valid = state_q == WR_XFER;
    assign blk_we       = we_q;
    assign blk_drive    = drv_q;
    assign blk_lba      = lba_q;
    assign err          = err_q;
endmodule

// File: tb/tb_u765_sd_sched.sv
// tb_u765_sd_sched: randomized bench for u765_sd_sched against a request-level
// model of arbitration, sector contents and handshake timing.
`timescale 1ns/1ps
module tb_u765_sd_sched;
    localparam int TMO = 1000;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] sd_lba = '0;
    logic [1:0]  sd_rd = '0, sd_wr = '0;
    logic        sd_ack, sd_buff_wr, blk_req, blk_we, blk_drive, blk_rd_ready, blk_wr_valid, busy, err;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din, blk_wr_data;
    logic [31:0] blk_lba;
    logic        blk_gnt = 0, blk_rd_valid = 0, blk_wr_ready = 0, blk_done = 0, blk_err = 0;
    logic [7:0]  blk_rd_data = '0;
    logic [33:0] outs;

    int   n_chk = 0, n_err = 0, cyc = 0, lat = 0, errp = 0;
    logic mprio = 1'b0;
    logic [8:0] wa[$];
    logic [7:0] wd[$], rq[$];
    int         wc[$], bc[$];

    u765_sd_sched #(.TIMEOUT_CYCLES(24'(TMO))) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .blk_req(blk_req), .blk_gnt(blk_gnt),
        .blk_we(blk_we), .blk_drive(blk_drive), .blk_lba(blk_lba), .blk_rd_data(blk_rd_data),
        .blk_rd_valid(blk_rd_valid), .blk_rd_ready(blk_rd_ready), .blk_wr_data(blk_wr_data),
        .blk_wr_valid(blk_wr_valid), .blk_wr_ready(blk_wr_ready), .blk_done(blk_done),
        .blk_err(blk_err), .busy(busy), .err(err)
    );

    assign outs = {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, blk_req, blk_we, blk_drive,
                   blk_rd_ready, blk_wr_data, blk_wr_valid, busy, err};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // FDC image buffer: synchronous read, contents addr[7:0]^0x5A
    always @(posedge clk) sd_buff_din <= sd_buff_addr[7:0] ^ 8'h5A;
    always @(negedge clk) begin
        if (sd_buff_wr) begin
            wa.push_back(sd_buff_addr);
            wd.push_back(sd_buff_dout);
            wc.push_back(cyc);
        end
        if (err) errp <= errp + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {drive, we}: lone requester wins, a tie goes to prio, read beats write
    function automatic logic [1:0] pick(input logic [1:0] rd, input logic [1:0] wr, input logic p);
        logic [1:0] c;
        logic       d;
        c = rd | wr;
        d = (c == 2'b11) ? p : c[1];
        return {d, ~rd[d]};
    endfunction

    // mode: 0 normal, 1 blk_err at byte arg, 2 backend stall after arg bytes,
    //       3 done+err together at the end, 4 write with 5-cycle ready stall at byte arg,
    //       5 reset at byte arg
    task automatic serve(input logic [31:0] lba, input int mode, input int arg, input bit seq);
        logic [1:0] pw;
        logic       d, w, st;
        int         n, i, t, w0, e0, last;
        pw = pick(sd_rd, sd_wr, mprio);
        d = pw[1];
        w = pw[0];
        mprio = ~d;
        sd_lba = lba;
        w0 = wa.size();
        e0 = errp;
        rq.delete();
        bc.delete();
        n = 0;
        do begin tick(); n++; end while (!blk_req && n < 10);
        lat = n;
        check("req", blk_req, 1);
        check("ack_req", sd_ack, 1);
        check("drive", blk_drive, d);
        check("we", blk_we, w);
        check("lba", blk_lba, lba);
        repeat ($urandom_range(0, 3)) tick();
        blk_gnt = 1;
        tick();
        blk_gnt = 0;
        i = 0; t = 0; last = 0; st = 0;
        while (i < 512 && t < 6000) begin
            t++;
            if (mode == 5 && i == arg) begin
                blk_wr_ready = 0;
                blk_rd_valid = 0;
                rst = 1;
                #1;
                check("rst_lba", blk_lba, 0);
                check("rst_out", outs, 0);
                sd_rd = 0;
                sd_wr = 0;
                mprio = 0;
                tick();
                rst = 0;
                tick();
                return;
            end
            if (mode == 1 && i == arg) begin
                blk_rd_valid = 0;
                blk_err = 1;
                tick();
                blk_err = 0;
                break;
            end
            if (mode == 2 && i == arg) begin
                blk_rd_valid = 0;
                blk_wr_ready = 0;
                n = 0;
                do begin tick(); n++; end while (!err && n < TMO + 100);
                check("tmo_err", err, 1);
                check("tmo_win", n >= TMO - 1 && n <= TMO + 2, 1);
                break;
            end
            if (w) begin
                if (mode == 4 && i == arg && !st) begin
                    st = 1;
                    blk_wr_ready = 0;
                    n = 0;
                    while (!blk_wr_valid && n < 10) begin tick(); n++; end
                    repeat (5) begin
                        check("stall_v", blk_wr_valid, 1);
                        check("stall_d", blk_wr_data, 8'(i) ^ 8'h5A);
                        tick();
                    end
                end
                blk_wr_ready = $urandom_range(0, 2) != 0;
                if (blk_wr_valid && blk_wr_ready) begin
                    check("wdat", blk_wr_data, 8'(i) ^ 8'h5A);
                    if (i > 0) check("wgap", cyc - last >= 2, 1);
                    last = cyc;
                    i++;
                end
            end else begin
                blk_rd_valid = $urandom_range(0, 3) != 0;
                blk_rd_data = seq ? 8'(i) : 8'($urandom);
                if (blk_rd_valid && blk_rd_ready) begin
                    rq.push_back(blk_rd_data);
                    bc.push_back(cyc);
                    i++;
                end
            end
            tick();
        end
        blk_rd_valid = 0;
        blk_wr_ready = 0;
        if (mode == 0 || mode == 3 || mode == 4) begin
            check("beats", i, 512);
            repeat ($urandom_range(0, 3)) tick();
            check("ack_pre_done", sd_ack, 1);
            blk_done = 1;
            blk_err = mode == 3;
            tick();
            blk_done = 0;
            blk_err = 0;
            check("ack_post_done", sd_ack, 0);
            check("err_at_done", err, mode == 3);
        end else if (mode == 1) begin
            check("err_abort", err, 1);
            check("ack_abort", sd_ack, 0);
            check("rdy_abort", blk_rd_ready, 0);
        end
        check("rel_busy", busy, 1);
        repeat (3) begin
            tick();
            check("rel_hold", busy, 1);
        end
        check("err_once", err, 0);
        if (w) sd_wr[d] = 0;
        else sd_rd[d] = 0;
        tick();
        check("idle", busy, 0);
        check("err_cnt", errp - e0, mode == 1 || mode == 2 || mode == 3);
        if (!w) begin
            check("wr_cnt", wa.size() - w0, i);
            for (int j = 0; j < i && w0 + j < wa.size(); j++) begin
                check("baddr", wa[w0 + j], j);
                check("bdat", wd[w0 + j], rq[j]);
                check("blat", wc[w0 + j], bc[j] + 1);
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_lba", blk_lba, 0);
        check("rst_out", outs, 0);
        rst = 0;
        tick();
        sd_rd = 2'b01;
        serve(32'h12, 0, 0, 1);
        check("req_lat", lat, 1);
        sd_wr = 2'b10;
        serve($urandom, 4, 200, 0);
        repeat (2) begin
            sd_rd = 2'b11;
            serve($urandom, 0, 0, 0);
            serve($urandom, 0, 0, 0);
        end
        sd_rd = 2'b01;
        sd_wr = 2'b01;
        serve($urandom, 0, 0, 0);
        serve($urandom, 0, 0, 0);
        sd_rd = 2'b01;
        serve($urandom, 1, 100, 0);
        sd_rd = 2'b10;
        serve($urandom, 2, 10, 0);
        sd_wr = 2'b01;
        serve($urandom, 5, 300, 0);
        sd_rd = 2'b10;
        serve($urandom, 0, 0, 0);
        sd_rd = 2'b01;
        serve($urandom, 3, 0, 0);
        repeat (4) begin
            sd_rd = 2'($urandom);
            sd_wr = 2'($urandom);
            if ((sd_rd | sd_wr) == 2'b00) sd_rd = 2'b10;
            while ((sd_rd | sd_wr) != 2'b00) serve($urandom, 0, 0, 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
